// File: rtl/apb4_timer_mc.sv
// Multi-channel APB4 timer: one shared prescaler tick drives CH_NUM compare channels.
// Each channel counts up or down, periodic or one-shot, and raises a sticky maskable flag.
module apb4_timer_mc #(
  parameter int CH_NUM     = 4,
  parameter int CNT_WIDTH  = 32,
  parameter int PSCR_WIDTH = 20
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic [31:0]       paddr,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [31:0]       pwdata,
  output logic [31:0]       prdata,
  output logic              pready,
  output logic              pslverr,
  output logic              irq_o,
  output logic [CH_NUM-1:0] irq_vec_o
);

  localparam logic [5:0] CH_END = 6'(4 + 4 * CH_NUM);

  logic [5:0]  word;
  logic        access;
  logic        rd_en;
  logic        wr_ok;
  logic        addr_ok;
  logic        pscr_wr;
  logic        stat_wr;
  logic [31:0] rd_next;
  logic        unused_bits;

  assign word    = paddr[7:2];
  assign access  = psel & penable;
  assign rd_en   = access & ~pwrite;
  assign wr_ok   = access & pwrite & addr_ok;
  assign pscr_wr = wr_ok & (word == 6'd0);
  assign stat_wr = wr_ok & (word == 6'd1);

  // Channel slots use offsets 0..2; offset 3 of each slot and words 2..3 are holes.
  always_comb begin
    addr_ok = 1'b0;
    if (word == 6'd0 || word == 6'd1) begin
      addr_ok = 1'b1;
    end else if (word >= 6'd4 && word < CH_END && word[1:0] != 2'b11) begin
      addr_ok = 1'b1;
    end
  end

  // ---------------------------------------------------------------- prescaler
  logic [PSCR_WIDTH-1:0] pscr_reg;
  logic [PSCR_WIDTH-1:0] pscr_cnt_reg;
  logic [PSCR_WIDTH-1:0] pscr_cnt_next;
  logic                  tick;

  assign tick = (pscr_cnt_reg == pscr_reg);

  always_comb begin
    pscr_cnt_next = tick ? '0 : pscr_cnt_reg + PSCR_WIDTH'(1);
    if (pscr_wr) begin
      pscr_cnt_next = '0;
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      pscr_reg     <= '0;
      pscr_cnt_reg <= '0;
    end else begin
      pscr_cnt_reg <= pscr_cnt_next;
      if (pscr_wr) begin
        pscr_reg <= pwdata[PSCR_WIDTH-1:0];
      end
    end
  end

  // ---------------------------------------------------------------- channels
  logic [CH_NUM-1:0] if_vec;
  logic [CH_NUM-1:0] irq_vec;
  logic [31:0]       ch_rd [CH_NUM];

  genvar gi;
  generate
    for (gi = 0; gi < CH_NUM; gi++) begin : g_ch
      localparam logic [5:0] CTRL_W = 6'(4 + 4 * gi);
      localparam logic [5:0] CMP_W  = 6'(5 + 4 * gi);
      localparam logic [5:0] CNT_W  = 6'(6 + 4 * gi);

      logic                 sel_ctrl;
      logic                 sel_cmp;
      logic                 sel_cnt;
      logic                 en_reg;
      logic                 en_next;
      logic                 ovie_reg;
      logic                 dir_reg;
      logic                 osm_reg;
      logic                 if_reg;
      logic                 if_next;
      logic [CNT_WIDTH-1:0] cmp_reg;
      logic [CNT_WIDTH-1:0] cnt_reg;
      logic [CNT_WIDTH-1:0] cnt_next;
      logic                 hit;
      logic                 evt;

      assign sel_ctrl = (word == CTRL_W);
      assign sel_cmp  = (word == CMP_W);
      assign sel_cnt  = (word == CNT_W);

      assign hit = dir_reg ? (cnt_reg == '0) : (cnt_reg == cmp_reg);
      assign evt = tick & en_reg & hit;

      // Later assignments carry priority: bus writes over the count/auto-disable,
      // and a fresh event over a W1C of the flag.
      always_comb begin
        cnt_next = cnt_reg;
        en_next  = en_reg;
        if_next  = if_reg;
        if (tick && en_reg) begin
          if (hit) begin
            cnt_next = dir_reg ? cmp_reg : '0;
          end else begin
            cnt_next = dir_reg ? cnt_reg - CNT_WIDTH'(1) : cnt_reg + CNT_WIDTH'(1);
          end
        end
        if (wr_ok && sel_cnt) begin
          cnt_next = pwdata[CNT_WIDTH-1:0];
        end
        if (evt && osm_reg) begin
          en_next = 1'b0;
        end
        if (wr_ok && sel_ctrl) begin
          en_next = pwdata[0];
        end
        if (stat_wr && pwdata[gi]) begin
          if_next = 1'b0;
        end
        if (evt) begin
          if_next = 1'b1;
        end
      end

      always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
          en_reg   <= 1'b0;
          ovie_reg <= 1'b0;
          dir_reg  <= 1'b0;
          osm_reg  <= 1'b0;
          if_reg   <= 1'b0;
          cmp_reg  <= '0;
          cnt_reg  <= '0;
        end else begin
          en_reg  <= en_next;
          if_reg  <= if_next;
          cnt_reg <= cnt_next;
          if (wr_ok && sel_ctrl) begin
            ovie_reg <= pwdata[1];
            dir_reg  <= pwdata[2];
            osm_reg  <= pwdata[3];
          end
          if (wr_ok && sel_cmp) begin
            cmp_reg <= pwdata[CNT_WIDTH-1:0];
          end
        end
      end

      assign ch_rd[gi] = sel_ctrl ? {27'd0, if_reg, osm_reg, dir_reg, ovie_reg, en_reg} :
                         sel_cmp  ? 32'(cmp_reg) :
                         sel_cnt  ? 32'(cnt_reg) : 32'd0;

      assign if_vec[gi]  = if_reg;
      assign irq_vec[gi] = if_reg & ovie_reg;
    end
  endgenerate

  // ---------------------------------------------------------------- read path
  always_comb begin
    rd_next = 32'd0;
    if (word == 6'd0) begin
      rd_next = 32'(pscr_reg);
    end else if (word == 6'd1) begin
      rd_next = 32'(if_vec);
    end
    for (int i = 0; i < CH_NUM; i++) begin
      rd_next = rd_next | ch_rd[i];
    end
  end

  assign prdata    = (presetn && rd_en && addr_ok) ? rd_next : 32'd0;
  assign pslverr   = presetn & access & ~addr_ok;
  assign pready    = 1'b1;
  assign irq_vec_o = irq_vec;
  assign irq_o     = |irq_vec;

  // Address bits outside the word index and write-data bits above the widest field are ignored.
  assign unused_bits = ^{paddr[31:8], paddr[1:0], pwdata};

endmodule

// File: tb/tb_apb4_timer_mc.sv
// Directed bench for apb4_timer_mc with CH_NUM=3, CNT_WIDTH=8.
// Reads sample the combinational read path in the low clock phase without consuming a cycle.
`timescale 1ns/1ps
module tb_apb4_timer_mc;
  localparam int CH_NUM     = 3;
  localparam int CNT_WIDTH  = 8;
  localparam int PSCR_WIDTH = 20;

  logic              pclk    = 1'b0;
  logic              presetn = 1'b0;
  logic [31:0]       paddr   = 32'd0;
  logic              psel    = 1'b0;
  logic              penable = 1'b0;
  logic              pwrite  = 1'b0;
  logic [31:0]       pwdata  = 32'd0;
  logic [31:0]       prdata;
  logic              pready;
  logic              pslverr;
  logic              irq_o;
  logic [CH_NUM-1:0] irq_vec_o;

  int n_cmp = 0;
  int n_err = 0;

  apb4_timer_mc #(
    .CH_NUM    (CH_NUM),
    .CNT_WIDTH (CNT_WIDTH),
    .PSCR_WIDTH(PSCR_WIDTH)
  ) dut (
    .pclk     (pclk),
    .presetn  (presetn),
    .paddr    (paddr),
    .psel     (psel),
    .penable  (penable),
    .pwrite   (pwrite),
    .pwdata   (pwdata),
    .prdata   (prdata),
    .pready   (pready),
    .pslverr  (pslverr),
    .irq_o    (irq_o),
    .irq_vec_o(irq_vec_o)
  );

  always #10 pclk = ~pclk;

  task automatic cyc(input int k);
    repeat (k) @(negedge pclk);
  endtask

  // Setup phase now, access phase next cycle; commits on the second rising edge.
  task automatic apb_wr(input logic [31:0] addr, input logic [31:0] data);
    psel = 1'b1; pwrite = 1'b1; penable = 1'b0; paddr = addr; pwdata = data;
    @(negedge pclk);
    penable = 1'b1;
    @(negedge pclk);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    $display("wr addr=%h data=%h", addr, data);
  endtask

  task automatic apb_rd(input logic [31:0] addr, output logic [31:0] data, output logic err);
    psel = 1'b1; pwrite = 1'b0; penable = 1'b1; paddr = addr;
    #1;
    data = prdata;
    err  = pslverr;
    psel = 1'b0; penable = 1'b0;
    $display("rd addr=%h data=%h err=%b", addr, data, err);
  endtask

  task automatic test_reset;
    logic [31:0] d;
    logic        e;
    logic [31:0] addrs [5];
    addrs = '{32'h00, 32'h04, 32'h10, 32'h14, 32'h18};
    cyc(1);
    apb_rd(32'h00, d, e);
    n_cmp++; if (d !== 32'd0) begin n_err++; $display("FAIL rst_prdata got=%h exp=0", d); end
    apb_rd(32'h40, d, e);
    n_cmp++; if (e !== 1'b0) begin n_err++; $display("FAIL rst_pslverr got=%b exp=0", e); end
    n_cmp++; if (irq_o !== 1'b0 || irq_vec_o !== 3'b000) begin
      n_err++; $display("FAIL rst_irq got=%b/%b exp=0/000", irq_o, irq_vec_o);
    end
    n_cmp++; if (pready !== 1'b1) begin n_err++; $display("FAIL pready got=%b exp=1", pready); end
    cyc(1);
    presetn = 1'b1;
    apb_wr(32'h00, 32'd0);
    apb_wr(32'h14, 32'd3);
    apb_wr(32'h10, 32'h3);
    cyc(8);
    n_cmp++; if (irq_o !== 1'b1) begin n_err++; $display("FAIL pre_reset_irq got=%b exp=1", irq_o); end
    #3 presetn = 1'b0;
    #1;
    n_cmp++; if (irq_o !== 1'b0 || irq_vec_o !== 3'b000) begin
      n_err++; $display("FAIL async_reset_irq got=%b/%b exp=0/000", irq_o, irq_vec_o);
    end
    cyc(1);
    presetn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      apb_rd(addrs[i], d, e);
      n_cmp++; if (d !== 32'd0) begin n_err++; $display("FAIL rst_reg[%h] got=%h exp=0", addrs[i], d); end
    end
    cyc(10);
    apb_rd(32'h18, d, e);
    n_cmp++; if (d !== 32'd0) begin n_err++; $display("FAIL rst_idle_cnt got=%h exp=0", d); end
    n_cmp++; if (irq_o !== 1'b0) begin n_err++; $display("FAIL rst_idle_irq got=%b exp=0", irq_o); end
  endtask

  task automatic test_periodic_up;
    logic [31:0] d;
    logic        e;
    logic [31:0] exp_cnt;
    apb_wr(32'h00, 32'd3);
    apb_wr(32'h14, 32'd5);
    apb_wr(32'h10, 32'h3);
    apb_rd(32'h00, d, e);
    n_cmp++; if (d !== 32'd3) begin n_err++; $display("FAIL pscr_rb got=%h exp=3", d); end
    // Tick every 4 cycles; the enable edge itself does not count.
    for (int r = 0; r <= 24; r++) begin
      exp_cnt = 32'((r / 4) % 6);
      apb_rd(32'h18, d, e);
      n_cmp++; if (d !== exp_cnt) begin n_err++; $display("FAIL up_cnt r=%0d got=%h exp=%h", r, d, exp_cnt); end
      n_cmp++; if (irq_o !== (r == 24)) begin n_err++; $display("FAIL up_irq r=%0d got=%b exp=%b", r, irq_o, r == 24); end
      if (r < 24) cyc(1);
    end
    apb_rd(32'h10, d, e);
    n_cmp++; if (d !== 32'h13) begin n_err++; $display("FAIL up_ctrl got=%h exp=13", d); end
    apb_wr(32'h04, 32'h1);
    n_cmp++; if (irq_o !== 1'b0) begin n_err++; $display("FAIL up_w1c_irq got=%b exp=0", irq_o); end
    apb_rd(32'h04, d, e);
    n_cmp++; if (d !== 32'd0) begin n_err++; $display("FAIL up_w1c_stat got=%h exp=0", d); end
    apb_wr(32'h10, 32'h0);
  endtask

  task automatic test_oneshot_down;
    logic [31:0] d;
    logic        e;
    logic [31:0] exp_cnt;
    apb_wr(32'h00, 32'd0);
    apb_wr(32'h28, 32'd3);
    apb_wr(32'h24, 32'd7);
    apb_wr(32'h20, 32'hF);
    for (int r = 0; r <= 8; r++) begin
      exp_cnt = (r < 4) ? 32'(3 - r) : 32'd7;
      apb_rd(32'h28, d, e);
      n_cmp++; if (d !== exp_cnt) begin n_err++; $display("FAIL osm_cnt r=%0d got=%h exp=%h", r, d, exp_cnt); end
      n_cmp++; if (irq_vec_o !== ((r >= 4) ? 3'b010 : 3'b000)) begin
        n_err++; $display("FAIL osm_irqvec r=%0d got=%b", r, irq_vec_o);
      end
      if (r == 4) begin
        apb_rd(32'h20, d, e);
        n_cmp++; if (d !== 32'h1E) begin n_err++; $display("FAIL osm_ctrl got=%h exp=1e", d); end
      end
      cyc(1);
    end
    apb_wr(32'h20, 32'h0);
    apb_wr(32'h04, 32'h2);
    apb_rd(32'h04, d, e);
    n_cmp++; if (d !== 32'd0) begin n_err++; $display("FAIL osm_clr got=%h exp=0", d); end
  endtask

  task automatic test_collision;
    logic [31:0] d;
    logic        e;
    apb_wr(32'h18, 32'd0);
    apb_wr(32'h14, 32'd3);
    apb_wr(32'h10, 32'h3);
    // Events land on enable edge +4, +8, ...
    cyc(4);
    apb_rd(32'h04, d, e);
    n_cmp++; if (d !== 32'd1) begin n_err++; $display("FAIL coll_first_evt got=%h exp=1", d); end
    apb_wr(32'h04, 32'h1);
    apb_rd(32'h04, d, e);
    n_cmp++; if (d !== 32'd0) begin n_err++; $display("FAIL coll_plain_w1c got=%h exp=0", d); end
    apb_rd(32'h18, d, e);
    n_cmp++; if (d !== 32'd2) begin n_err++; $display("FAIL coll_cnt_mid got=%h exp=2", d); end
    apb_wr(32'h04, 32'h1);
    apb_rd(32'h04, d, e);
    n_cmp++; if (d !== 32'd1) begin n_err++; $display("FAIL coll_evt_beats_w1c got=%h exp=1", d); end
    apb_rd(32'h18, d, e);
    n_cmp++; if (d !== 32'd0) begin n_err++; $display("FAIL coll_cnt_evt got=%h exp=0", d); end
    apb_wr(32'h18, 32'h10);
    apb_rd(32'h18, d, e);
    n_cmp++; if (d !== 32'h10) begin n_err++; $display("FAIL coll_cnt_wr got=%h exp=10", d); end
    cyc(1);
    apb_rd(32'h18, d, e);
    n_cmp++; if (d !== 32'h11) begin n_err++; $display("FAIL coll_cnt_after got=%h exp=11", d); end
    apb_wr(32'h10, 32'h0);
    apb_wr(32'h04, 32'h7);
  endtask

  task automatic test_multi_channel;
    logic [31:0] d;
    logic        e;
    apb_wr(32'h18, 32'd0);
    apb_wr(32'h14, 32'd2);
    apb_wr(32'h34, 32'd4);
    apb_wr(32'h10, 32'h1);
    apb_wr(32'h30, 32'h3);
    cyc(10);
    apb_rd(32'h04, d, e);
    n_cmp++; if (d !== 32'h5) begin n_err++; $display("FAIL multi_stat got=%h exp=5", d); end
    n_cmp++; if (irq_vec_o !== 3'b100) begin n_err++; $display("FAIL multi_irqvec got=%b exp=100", irq_vec_o); end
    n_cmp++; if (irq_o !== 1'b1) begin n_err++; $display("FAIL multi_irq got=%b exp=1", irq_o); end
    apb_rd(32'h40, d, e);
    n_cmp++; if (e !== 1'b1 || d !== 32'd0) begin n_err++; $display("FAIL err_ch3 got=%b/%h exp=1/0", e, d); end
    apb_rd(32'h08, d, e);
    n_cmp++; if (e !== 1'b1) begin n_err++; $display("FAIL err_hole08 got=%b exp=1", e); end
    apb_rd(32'h1C, d, e);
    n_cmp++; if (e !== 1'b1) begin n_err++; $display("FAIL err_hole1c got=%b exp=1", e); end
    apb_wr(32'h04 | 32'h40, 32'hFFFF_FFFF);
    apb_rd(32'h30, d, e);
    n_cmp++; if (e !== 1'b0 || d !== 32'h13) begin n_err++; $display("FAIL ctrl2 got=%b/%h exp=0/13", e, d); end
    apb_wr(32'h30, 32'h1);
    n_cmp++; if (irq_o !== 1'b0) begin n_err++; $display("FAIL mask_irq got=%b exp=0", irq_o); end
    apb_rd(32'h04, d, e);
    n_cmp++; if (d !== 32'h5) begin n_err++; $display("FAIL mask_keeps_if got=%h exp=5", d); end
    apb_wr(32'h10, 32'h0);
    apb_wr(32'h30, 32'h0);
    apb_wr(32'h04, 32'h7);
    apb_rd(32'h04, d, e);
    n_cmp++; if (d !== 32'd0) begin n_err++; $display("FAIL multi_clr got=%h exp=0", d); end
  endtask

  task automatic test_wrap;
    logic [31:0] d;
    logic        e;
    logic [7:0]  e8;
    apb_wr(32'h14, 32'h05);
    apb_wr(32'h18, 32'hFE);
    apb_wr(32'h10, 32'h1);
    for (int r = 0; r <= 8; r++) begin
      e8 = (r == 8) ? 8'h00 : 8'hFE + 8'(r);
      apb_rd(32'h18, d, e);
      n_cmp++; if (d !== 32'(e8)) begin n_err++; $display("FAIL wrap_cnt r=%0d got=%h exp=%h", r, d, e8); end
      apb_rd(32'h04, d, e);
      n_cmp++; if (d !== ((r == 8) ? 32'd1 : 32'd0)) begin n_err++; $display("FAIL wrap_stat r=%0d got=%h", r, d); end
      if (r < 8) cyc(1);
    end
    apb_wr(32'h10, 32'h0);
  endtask

  initial begin
    test_reset();
    test_periodic_up();
    test_oneshot_down();
    test_collision();
    test_multi_channel();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

endmodule
